// File: rtl/reg_rr_arbiter.sv
// reg_rr_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that lets NUM_MST register-bus masters share a single
// register-bus slave. One master is granted at a time. The grant is held until
// the slave completes, the transfer times out, or the master withdraws its
// request. After a completion or a timeout, priority moves to the master that
// follows the one just served.
//
// Handshake (every master port and the slave port):
//   valid is held high until ready is seen high in the same cycle. addr,
//   write, wdata and wstrb stay stable while valid is high. ready, rdata and
//   error carry meaning only in the cycle where valid and ready are both high.
//
// Ports:
//   clk_i, rst_ni      rising-edge clock; synchronous active-low reset
//   mst_valid_i        per-master request
//   mst_write_i        per-master write flag
//   mst_addr_i         per-master byte address
//   mst_wdata_i        per-master write data
//   mst_wstrb_i        per-master byte strobes
//   mst_ready_o        per-master completion (one-hot or zero)
//   mst_rdata_o        per-master read data (zero for non-granted masters)
//   mst_error_o        per-master error (zero for non-granted masters)
//   slv_valid_o, slv_write_o, slv_addr_o, slv_wdata_o, slv_wstrb_o
//                      request forwarded to the slave
//   slv_ready_i, slv_rdata_i, slv_error_i
//                      response from the slave
//   busy_o             high while a grant is held
//   dbg_state_o        FSM state (0 = IDLE, 1 = BUSY), for observation only
// ----------------------------------------------------------------------------
module reg_rr_arbiter #(
  parameter int unsigned NUM_MST    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_MST-1:0]                     mst_valid_i,
  input  logic [NUM_MST-1:0]                     mst_write_i,
  input  logic [NUM_MST-1:0][ADDR_WIDTH-1:0]     mst_addr_i,
  input  logic [NUM_MST-1:0][DATA_WIDTH-1:0]     mst_wdata_i,
  input  logic [NUM_MST-1:0][DATA_WIDTH/8-1:0]   mst_wstrb_i,
  output logic [NUM_MST-1:0]                     mst_ready_o,
  output logic [NUM_MST-1:0][DATA_WIDTH-1:0]     mst_rdata_o,
  output logic [NUM_MST-1:0]                     mst_error_o,
  output logic                                   slv_valid_o,
  output logic                                   slv_write_o,
  output logic [ADDR_WIDTH-1:0]                  slv_addr_o,
  output logic [DATA_WIDTH-1:0]                  slv_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                slv_wstrb_o,
  input  logic                                   slv_ready_i,
  input  logic [DATA_WIDTH-1:0]                  slv_rdata_i,
  input  logic                                   slv_error_i,
  output logic                                   busy_o,
  output logic                                   dbg_state_o
);

  localparam int unsigned IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  // A zero TIMEOUT still needs a one-bit counter so the code stays legal.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     prio_q, prio_d;
  logic [CNT_W-1:0]     tcnt_q, tcnt_d;

  logic [IDX_W-1:0]     pick;
  logic [IDX_W-1:0]     prio_next;
  logic                 active;
  logic                 sel_valid;
  logic                 timeout_fire;
  logic                 complete;
  logic                 abandon;

  // --------------------------------------------------------------------------
  // Round-robin pick: first requester scanning upward from prio_q, wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    pick  = prio_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(NUM_MST); k++) begin
      idx = IDX_W'((int'(prio_q) + k) % int'(NUM_MST));
      if (!found && mst_valid_i[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign prio_next = IDX_W'((int'(grant_q) + 1) % int'(NUM_MST));

  // --------------------------------------------------------------------------
  // Transfer status for the held grant. Outputs are gated by rst_ni so that
  // a reset cycle in the middle of a transfer never leaks a ready pulse.
  // --------------------------------------------------------------------------
  assign active    = (state_q == BUSY) && rst_ni;
  assign sel_valid = mst_valid_i[grant_q];

  always_comb begin
    timeout_fire = 1'b0;
    if (TIMEOUT > 0) begin
      timeout_fire = active && sel_valid && (tcnt_q == CNT_LAST) && !slv_ready_i;
    end
  end

  assign complete = active && sel_valid && slv_ready_i;
  assign abandon  = active && !sel_valid;

  // --------------------------------------------------------------------------
  // Output multiplexing: slave side mirrors the held master, the response is
  // routed back only to that master. A timeout answers the master locally
  // with an error and zero data while the slave request is withdrawn.
  // --------------------------------------------------------------------------
  always_comb begin
    slv_valid_o = 1'b0;
    slv_write_o = 1'b0;
    slv_addr_o  = '0;
    slv_wdata_o = '0;
    slv_wstrb_o = '0;
    mst_ready_o = '0;
    mst_rdata_o = '0;
    mst_error_o = '0;
    if (active) begin
      slv_valid_o          = sel_valid && !timeout_fire;
      slv_write_o          = mst_write_i[grant_q];
      slv_addr_o           = mst_addr_i[grant_q];
      slv_wdata_o          = mst_wdata_i[grant_q];
      slv_wstrb_o          = mst_wstrb_i[grant_q];
      mst_ready_o[grant_q] = complete || timeout_fire;
      mst_rdata_o[grant_q] = timeout_fire ? '0 : slv_rdata_i;
      mst_error_o[grant_q] = timeout_fire || slv_error_i;
    end
  end

  assign busy_o      = (state_q == BUSY) && rst_ni;
  assign dbg_state_o = state_q;

  // --------------------------------------------------------------------------
  // Next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (|mst_valid_i) begin
          state_d = BUSY;
          grant_d = pick;
          tcnt_d  = '0;
        end
      end
      BUSY: begin
        if (complete || timeout_fire) begin
          state_d = IDLE;
          prio_d  = prio_next;
        end else if (abandon) begin
          // Withdrawn request: release the slave, keep the priority order.
          state_d = IDLE;
        end else if (TIMEOUT > 0) begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      prio_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Testbench for reg_rr_arbiter: three masters, TIMEOUT=4. Directed scenarios
// with literal expectations, then a long randomized phase. A behavioural model
// predicts every output at each falling clock edge.
module tb_reg_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]          mst_valid = '0;
  logic [N-1:0]          mst_write = '0;
  logic [N-1:0][AW-1:0]  mst_addr  = '0;
  logic [N-1:0][DW-1:0]  mst_wdata = '0;
  logic [N-1:0][SW-1:0]  mst_wstrb = '0;
  logic [N-1:0]          mst_ready;
  logic [N-1:0][DW-1:0]  mst_rdata;
  logic [N-1:0]          mst_error;
  logic                  slv_valid, slv_write;
  logic [AW-1:0]         slv_addr;
  logic [DW-1:0]         slv_wdata;
  logic [SW-1:0]         slv_wstrb;
  logic                  slv_ready = 1'b0;
  logic [DW-1:0]         slv_rdata = '0;
  logic                  slv_error = 1'b0;
  logic                  busy;
  logic                  dbg_state;

  reg_rr_arbiter #(
    .NUM_MST(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_valid_i(mst_valid), .mst_write_i(mst_write), .mst_addr_i(mst_addr),
    .mst_wdata_i(mst_wdata), .mst_wstrb_i(mst_wstrb),
    .mst_ready_o(mst_ready), .mst_rdata_o(mst_rdata), .mst_error_o(mst_error),
    .slv_valid_o(slv_valid), .slv_write_o(slv_write), .slv_addr_o(slv_addr),
    .slv_wdata_o(slv_wdata), .slv_wstrb_o(slv_wstrb),
    .slv_ready_i(slv_ready), .slv_rdata_i(slv_rdata), .slv_error_i(slv_error),
    .busy_o(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [N-1:0] rdy_seen = '0;
  logic [N-1:0] hold     = '0;
  bit          chk_order = 1'b0;
  logic [1:0]  exp_q[$];
  int          ready_cnt[N];

  // behavioural model state
  bit m_busy  = 1'b0;
  int m_grant = 0;
  int m_prio  = 0;
  int m_age   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; masters whose transfer
  // completed on that edge drop valid unless held.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int m = 0; m < N; m++)
      if (rdy_seen[m] && !hold[m]) mst_valid[m] = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic req(input int m, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [SW-1:0] s);
    mst_write[m] = wr;
    mst_addr[m]  = a;
    mst_wdata[m] = d;
    mst_wstrb[m] = s;
    mst_valid[m] = 1'b1;
  endtask

  task automatic reset_dut();
    tick();
    rst_n = 1'b0;
    mst_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard / model ----------------
  always @(negedge clk) begin : scoreboard
    logic [N-1:0] e_ready;
    bit           e_sv, to, req_g, found;
    int           idx, cur;
    e_ready = '0; e_sv = 1'b0; to = 1'b0; req_g = 1'b0; found = 1'b0; idx = 0; cur = 0;

    if (rst_n && m_busy) begin
      req_g = mst_valid[m_grant];
      to    = (m_age == TO) && req_g && !slv_ready;
      e_sv  = req_g && !to;
      if ((e_sv && slv_ready) || to) e_ready[m_grant] = 1'b1;
    end

    chk("busy_o", busy, rst_n && m_busy);
    chk("slv_valid_o", slv_valid, e_sv);
    chk("mst_ready_o", mst_ready, e_ready);
    if (e_sv) begin
      chk("slv_addr_o",  slv_addr,  mst_addr[m_grant]);
      chk("slv_write_o", slv_write, mst_write[m_grant]);
      chk("slv_wdata_o", slv_wdata, mst_wdata[m_grant]);
      chk("slv_wstrb_o", slv_wstrb, mst_wstrb[m_grant]);
    end
    for (int m = 0; m < N; m++) begin
      if (!(rst_n && m_busy && m == m_grant)) begin
        chk("idle_rdata", mst_rdata[m], '0);
        chk("idle_error", mst_error[m], '0);
      end else if (e_ready[m]) begin
        chk("resp_rdata", mst_rdata[m], to ? '0 : slv_rdata);
        chk("resp_error", mst_error[m], to ? 1'b1 : slv_error);
      end
    end

    rdy_seen = mst_ready;
    for (int m = 0; m < N; m++) ready_cnt[m] += int'(mst_ready[m]);
    if (chk_order && |mst_ready) begin
      for (int m = 0; m < N; m++) if (mst_ready[m]) cur = m;
      chk("grant_order", cur, (exp_q.size() == 0) ? 3 : exp_q.pop_front());
    end

    // advance the model by one clock
    if (!rst_n) begin
      m_busy = 1'b0; m_grant = 0; m_prio = 0; m_age = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_prio + k) % N;
        if (!found && mst_valid[idx]) begin
          found = 1'b1; m_grant = idx;
        end
      end
      if (found) begin
        m_busy = 1'b1; m_age = 1;
      end
    end else if (e_ready[m_grant]) begin
      m_busy = 1'b0; m_prio = (m_grant + 1) % N;
    end else if (!req_g) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    foreach (ready_cnt[m]) ready_cnt[m] = 0;
    tick(); tick();
    rst_n = 1'b1;
    sample();
    chk("rst_busy", busy, 1'b0);
    chk("rst_slv_valid", slv_valid, 1'b0);
    chk("rst_ready", mst_ready, '0);
    chk("rst_rdata", mst_rdata, '0);

    // single write, slave ready immediately
    tick();
    slv_ready = 1'b1;
    req(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    sample();
    chk("t1_pre_valid", slv_valid, 1'b0);
    tick(); sample();
    chk("t1_valid", slv_valid, 1'b1);
    chk("t1_write", slv_write, 1'b1);
    chk("t1_addr", slv_addr, 32'h4);
    chk("t1_wdata", slv_wdata, 32'hDEADBEEF);
    chk("t1_wstrb", slv_wstrb, 4'hF);
    chk("t1_ready", mst_ready, 3'b001);
    chk("t1_busy", busy, 1'b1);
    tick(); sample();
    chk("t1_post_valid", slv_valid, 1'b0);
    chk("t1_post_busy", busy, 1'b0);

    // all three masters request continuously, slave always ready
    reset_dut();
    foreach (ready_cnt[m]) ready_cnt[m] = 0;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    chk_order = 1'b1;
    hold = 3'b111;
    slv_ready = 1'b1;
    for (int m = 0; m < N; m++) req(m, 1'b0, 32'h100 + 32'(m * 4), '0, '0);
    repeat (12) tick();
    hold = '0;
    mst_valid = '0;
    chk_order = 1'b0;
    chk("rot_left", exp_q.size(), 0);
    for (int m = 0; m < N; m++) chk("rot_count", ready_cnt[m], 2);

    // slave stalls three cycles, then answers
    reset_dut();
    slv_ready = 1'b0;
    req(0, 1'b0, 32'h8, '0, '0);
    req(2, 1'b1, 32'h10, 32'hA5A5A5A5, 4'h3);
    repeat (3) begin
      tick(); sample();
      chk("stall_ready", mst_ready, '0);
    end
    tick();
    slv_ready = 1'b1; slv_rdata = 32'h12345678; slv_error = 1'b0;
    sample();
    chk("stall_done", mst_ready, 3'b001);
    chk("stall_rdata0", mst_rdata[0], 32'h12345678);
    chk("stall_rdata2", mst_rdata[2], '0);
    tick(); tick(); sample();
    chk("stall_next", mst_ready, 3'b100);
    chk("stall_next_addr", slv_addr, 32'h10);
    tick();
    slv_ready = 1'b0;

    // slave never ready: timeout on master 0, then master 1 is granted
    reset_dut();
    slv_ready = 1'b0; slv_rdata = 32'hFFFF0000;
    req(0, 1'b0, 32'h18, '0, '0);
    req(1, 1'b0, 32'h20, '0, '0);
    repeat (3) begin
      tick(); sample();
      chk("to_wait_ready", mst_ready, '0);
    end
    tick(); sample();
    chk("to_ready", mst_ready, 3'b001);
    chk("to_error", mst_error, 3'b001);
    chk("to_rdata", mst_rdata[0], '0);
    chk("to_slv_valid", slv_valid, 1'b0);
    tick(); sample();
    chk("to_gap_busy", busy, 1'b0);
    tick(); sample();
    chk("to_next_valid", slv_valid, 1'b1);
    chk("to_next_addr", slv_addr, 32'h20);

    // reset in the middle of a transfer
    reset_dut();
    slv_ready = 1'b1;
    req(0, 1'b0, 32'h28, '0, '0);
    tick(); tick();
    slv_ready = 1'b0;
    req(1, 1'b0, 32'h30, '0, '0);
    tick(); tick();
    rst_n = 1'b0; slv_ready = 1'b1;
    sample();
    chk("mid_rst_ready", mst_ready, '0);
    chk("mid_rst_valid", slv_valid, 1'b0);
    tick();
    rst_n = 1'b1; slv_ready = 1'b0;
    req(0, 1'b0, 32'h40, '0, '0);
    sample();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", mst_ready, '0);
    tick(); sample();
    chk("post_rst_grant", slv_addr, 32'h40);

    // slave error on a read, priority rotates afterwards
    reset_dut();
    slv_ready = 1'b1; slv_error = 1'b1; slv_rdata = 32'hCAFE0001;
    req(0, 1'b0, 32'h50, '0, '0);
    tick(); sample();
    chk("err_ready", mst_ready, 3'b001);
    chk("err_error", mst_error, 3'b001);
    chk("err_rdata", mst_rdata[0], 32'hCAFE0001);
    tick();
    slv_error = 1'b0;
    req(0, 1'b0, 32'h60, '0, '0);
    req(1, 1'b0, 32'h64, '0, '0);
    tick(); sample();
    chk("err_rot_ready", mst_ready, 3'b010);
    chk("err_rot_addr", slv_addr, 32'h64);

    // randomized traffic
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      for (int m = 0; m < N; m++) begin
        if (mst_valid[m]) begin
          if ($urandom_range(0, 99) == 0) mst_valid[m] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req(m, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
        end
      end
      slv_ready = 1'($urandom_range(0, 1));
      slv_rdata = $urandom;
      slv_error = ($urandom_range(0, 7) == 0);
    end
    rst_n = 1'b1;
    mst_valid = '0;
    tick(); tick(); tick();
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
